// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   state_e         : sequencer states (IDLE, ACCESS, RESP)
//   PORT0 / PORT1   : master identifiers used for ownership and pointer
//   DEFAULT_ADDR_HI : highest byte-address bit decoded by the 16K x 32 memory
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int unsigned DEFAULT_ADDR_HI = 15;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset (pointer -> port 0)
//   en         : arbitration allowed this cycle
//   req[1:0]   : request per port
//   gnt[1:0]   : one-hot grant (combinational)
// The pointer names the favoured port on a tie; after any grant it moves to
// the port that did not win.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en) begin
      // A lone requester wins regardless of the pointer.
      if (req[0] && (!req[1] || ptr_q == PORT0)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
    if (gnt[0]) begin
      ptr_d = PORT1;
    end else if (gnt[1]) begin
      ptr_d = PORT0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= PORT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the word-addressed data
// memory. Port 0 is the CPU load/store unit, port 1 a secondary master.
//   clk, reset            : clock, asynchronous active-high reset
//   mN_req/we/addr/wdata  : master command, held stable until mN_gnt
//   mN_gnt                : combinational accept, command latched at the edge
//   mN_rvalid/rdata/err   : one-cycle response to the owning master only
//   mem_write/read/addr/wdata, mem_rdata : single memory port
// Each access takes grant (G), memory strobe (G+1) and response (G+2); a new
// grant may overlap the response cycle. Misaligned or out-of-range addresses
// are flagged at grant and never strobe the memory.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_HI = DEFAULT_ADDR_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  gnt;
  logic        can_grant;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic        mem_en;
  logic        in_resp;

  // Gating with reset keeps gnt low while reset is held.
  assign can_grant = (state_q != ACCESS) && !reset;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (can_grant),
    .req   ({m1_req, m0_req}),
    .gnt   (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    sel_we    = gnt[1] ? m1_we    : m0_we;
    sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) ||
                ((sel_addr >> (ADDR_HI + 1)) != 32'd0);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (|gnt) begin
          state_d = ACCESS;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          owner_d = gnt[1] ? PORT1 : PORT0;
          err_d   = sel_err;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (!we_q && !err_q) ? mem_rdata : '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= PORT0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes derive from the asynchronously reset state, so reset mid-access
  // removes them before the write edge.
  assign mem_en    = (state_q == ACCESS) && !err_q;
  assign mem_write = mem_en && we_q;
  assign mem_read  = mem_en && !we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  assign in_resp   = (state_q == RESP);
  assign m0_rvalid = in_resp && (owner_q == PORT0);
  assign m1_rvalid = in_resp && (owner_q == PORT1);
  assign m0_err    = m0_rvalid && err_q;
  assign m1_err    = m1_rvalid && err_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_HI(15)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory: 16K x 32, write on posedge, gated combinational read.
  logic [31:0] env_mem [0:16383];
  assign mem_rdata = mem_read ? env_mem[mem_addr[15:2]] : 32'd0;
  initial begin
    for (int i = 0; i < 16384; i++) env_mem[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (mem_write) env_mem[mem_addr[15:2]] = mem_wdata;
    end
  end

  // Reference model: transaction list keyed by grant cycle, shadow memory.
  typedef struct {
    int          g;
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rd;
  } txn_t;

  txn_t        pend[$];
  logic [31:0] ref_mem [0:16383];
  int          next_ok = 0;
  int          ptr = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          seen_gnt [2];
  bit          seen_rv [2];
  int          g_cyc [2];
  int          rv_cyc [2];
  logic [31:0] last_rd [2];
  bit          last_err [2];
  int          glog_port[$];
  int          glog_cyc[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:16] != 16'd0);
  endfunction

  // Runs at the negedge: derive expected outputs for this cycle, compare.
  task automatic check_cycle();
    logic e_g0, e_g1, e_mw, e_mr, e_rv0, e_rv1, e_er0, e_er1;
    logic [31:0] e_ma, e_mwd, e_rd0, e_rd1;
    int w;
    txn_t t;
    e_g0 = 0; e_g1 = 0; e_mw = 0; e_mr = 0; e_rv0 = 0; e_rv1 = 0;
    e_er0 = 0; e_er1 = 0; e_ma = '0; e_mwd = '0; e_rd0 = '0; e_rd1 = '0;
    if (reset) begin
      pend.delete();
      ptr = 0;
      next_ok = cyc;
    end else begin
      foreach (pend[i]) begin
        if (pend[i].g == cyc - 1 && !pend[i].err) begin
          e_mw = pend[i].we; e_mr = !pend[i].we;
          e_ma = pend[i].addr; e_mwd = pend[i].wdata;
          if (pend[i].we) ref_mem[pend[i].addr[15:2]] = pend[i].wdata;
          else pend[i].rd = ref_mem[pend[i].addr[15:2]];
        end
        if (pend[i].g == cyc - 2) begin
          if (pend[i].port == 0) begin
            e_rv0 = 1; e_rd0 = pend[i].rd; e_er0 = pend[i].err;
          end else begin
            e_rv1 = 1; e_rd1 = pend[i].rd; e_er1 = pend[i].err;
          end
        end
      end
      while (pend.size() > 0 && pend[0].g <= cyc - 2) void'(pend.pop_front());
      if (cyc >= next_ok && (m0_req || m1_req)) begin
        w = (m0_req && m1_req) ? ptr : (m1_req ? 1 : 0);
        t.g = cyc; t.port = w; t.rd = '0;
        t.we    = (w == 0) ? m0_we    : m1_we;
        t.addr  = (w == 0) ? m0_addr  : m1_addr;
        t.wdata = (w == 0) ? m0_wdata : m1_wdata;
        t.err   = addr_bad(t.addr);
        pend.push_back(t);
        next_ok = cyc + 2;
        ptr = 1 - w;
        if (w == 0) e_g0 = 1; else e_g1 = 1;
      end
    end
    chk1("m0_gnt", m0_gnt, e_g0);
    chk1("m1_gnt", m1_gnt, e_g1);
    chk1("mem_write", mem_write, e_mw);
    chk1("mem_read", mem_read, e_mr);
    chk32("mem_addr", mem_addr, e_ma);
    chk32("mem_wdata", mem_wdata, e_mwd);
    chk1("m0_rvalid", m0_rvalid, e_rv0);
    chk1("m1_rvalid", m1_rvalid, e_rv1);
    chk1("m0_err", m0_err, e_er0);
    chk1("m1_err", m1_err, e_er1);
    chk32("m0_rdata", m0_rdata, e_rd0);
    chk32("m1_rdata", m1_rdata, e_rd1);
    seen_gnt[0] = m0_gnt; seen_gnt[1] = m1_gnt;
    seen_rv[0] = m0_rvalid; seen_rv[1] = m1_rvalid;
    for (int p = 0; p < 2; p++) begin
      if (seen_gnt[p]) begin
        g_cyc[p] = cyc; glog_port.push_back(p); glog_cyc.push_back(cyc);
      end
      if (seen_rv[p]) begin
        rv_cyc[p] = cyc;
        last_rd[p] = (p == 0) ? m0_rdata : m1_rdata;
        last_err[p] = (p == 0) ? m0_err : m1_err;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 0;
    set_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = seen_gnt[p];
    end
    if (!got) chk1("gnt_timeout", 1'b0, 1'b1);
    set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_resp(input int p);
    bit got;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = seen_rv[p];
    end
    if (!got) chk1("rvalid_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = 32'($urandom_range(0, 63)) << 2;
    if (k == 0) a = a | 32'($urandom_range(1, 3));
    else if (k == 1) a = a | (32'd1 << $urandom_range(16, 31));
    return a;
  endfunction

  initial begin
    int c0;
    int rst_cnt;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'd0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    reset = 1'b1;
    #1;

    // Reset for 3 cycles, then idle with no requests.
    do_reset(3);
    for (int i = 0; i < 4; i++) tick();

    // Write then read back at 0x10 from port 0.
    do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_resp(0);
    chk32("wr_latency", 32'(rv_cyc[0] - g_cyc[0]), 32'd2);
    chk32("wr_rdata", last_rd[0], 32'd0);
    do_req(0, 1'b0, 32'h0000_0010, 32'd0);
    wait_resp(0);
    chk32("rd_latency", 32'(rv_cyc[0] - g_cyc[0]), 32'd2);
    chk32("rd_rdata", last_rd[0], 32'hDEAD_BEEF);
    chk1("rd_err", last_err[0], 1'b0);

    // Both ports requesting from reset alternate every two cycles.
    do_reset(2);
    glog_port.delete(); glog_cyc.delete();
    c0 = cyc;
    set_port(0, 1'b1, 1'b0, 32'h40, 32'd0);
    set_port(1, 1'b1, 1'b0, 32'h44, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk1("alt_count", glog_port.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < glog_port.size(); k++) begin
      chk32("alt_port", 32'(glog_port[k]), 32'(k % 2));
      chk32("alt_cycle", 32'(glog_cyc[k] - c0), 32'(2 * k));
    end

    // Rejected addresses from port 1.
    do_req(1, 1'b0, 32'h0000_0013, 32'd0);
    wait_resp(1);
    chk1("misalign_err", last_err[1], 1'b1);
    chk32("misalign_rdata", last_rd[1], 32'd0);
    do_req(1, 1'b0, 32'h0001_0000, 32'd0);
    wait_resp(1);
    chk1("range_err", last_err[1], 1'b1);
    chk32("range_rdata", last_rd[1], 32'd0);

    // Reset in the middle of a write access.
    do_req(0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    chk1("pre_reset_mw", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    chk1("reset_drops_mw", mem_write, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    do_req(0, 1'b0, 32'h0000_0020, 32'd0);
    wait_resp(0);
    chk32("aborted_write", last_rd[0], 32'd0);

    // Port 1 alone, back-to-back, pointer favouring port 0.
    do_reset(2);
    glog_port.delete(); glog_cyc.delete();
    c0 = cyc;
    set_port(1, 1'b1, 1'b0, 32'h48, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk1("solo_count", glog_port.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < glog_port.size(); k++) begin
      chk32("solo_port", 32'(glog_port[k]), 32'd1);
      chk32("solo_cycle", 32'(glog_cyc[k] - c0), 32'(2 * k));
    end

    // Randomized traffic with occasional resets and abandoned requests.
    rst_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst_cnt > 0) begin
        reset = 1'b1;
        rst_cnt--;
      end else begin
        reset = 1'b0;
        if ($urandom_range(0, 199) == 0) begin
          reset = 1'b1;
          rst_cnt = $urandom_range(0, 1);
        end
      end
      for (int p = 0; p < 2; p++) begin
        logic cur;
        cur = (p == 0) ? m0_req : m1_req;
        if (seen_gnt[p]) cur = 1'b0;
        if (!cur) begin
          if ($urandom_range(0, 1) == 1)
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom());
          else
            set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
        end else if ($urandom_range(0, 31) == 0) begin
          set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
      tick();
    end
    reset = 1'b0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
